// File: rtl/fixed_bcd_decoder_if.sv
// rtl/fixed_bcd_decoder_if.sv - start/done handshake bundle for the fixed-point BCD decoder
interface fixed_bcd_decoder_if;
    logic               start;
    logic signed [24:0] value;
    logic               busy;
    logic               done;
    logic [27:0]        bcd;
    logic               neg;
    logic               ovf;

    modport master (
        output start,
        output value,
        input  busy,
        input  done,
        input  bcd,
        input  neg,
        input  ovf
    );

    modport slave (
        input  start,
        input  value,
        output busy,
        output done,
        output bcd,
        output neg,
        output ovf
    );
endinterface

// File: rtl/fixed_bcd_decoder.sv
// rtl/fixed_bcd_decoder.sv - signed x1000 fixed-point to sign + 7 BCD digits, fixed-latency double dabble
module fixed_bcd_decoder (
    input logic                clk,
    input logic                rst,
    fixed_bcd_decoder_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    logic [4:0]  iter;
    logic [24:0] mag;
    logic [27:0] bcd_sr;
    logic        neg_r;
    logic        ovf_r;

    logic [24:0] value_u;
    logic [24:0] mag_in;
    logic [27:0] bcd_adj;

    // 25-bit negate keeps -16777216 as 16777216 without wrapping.
    always_comb begin
        value_u = bus.value;
        mag_in  = value_u[24] ? (~value_u + 25'd1) : value_u;
    end

    always_comb begin
        bcd_adj = bcd_sr;
        for (int i = 0; i < 7; i++) begin
            if (bcd_sr[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_sr[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            iter     <= 5'd0;
            mag      <= 25'd0;
            bcd_sr   <= 28'd0;
            neg_r    <= 1'b0;
            ovf_r    <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.bcd  <= 28'd0;
            bus.neg  <= 1'b0;
            bus.ovf  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        neg_r    <= value_u[24];
                        mag      <= mag_in;
                        ovf_r    <= (mag_in > 25'd9999999);
                        bcd_sr   <= 28'd0;
                        iter     <= 5'd0;
                        bus.busy <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Bits shifted past the top digit only matter when ovf_r is set.
                    {bcd_sr, mag} <= {bcd_adj[26:0], mag, 1'b0};
                    iter          <= iter + 5'd1;
                    if (iter == 5'd24) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bus.bcd  <= ovf_r ? 28'd0 : bcd_sr;
                    bus.neg  <= neg_r;
                    bus.ovf  <= ovf_r;
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                end
            endcase
        end
    end
endmodule
